// File: rtl/fifo_burst_reader_if.sv
// Bundle of the FWFT fifo read port and the outgoing valid/ready stream.
// master = burst reader side, slave = fifo + stream consumer side.
interface fifo_burst_reader_if #(
  parameter int unsigned DATA_BITS = 11
);
  logic [DATA_BITS-1:0] fifo_data;
  logic                 fifo_empty;
  logic                 fifo_read;
  logic [DATA_BITS-1:0] m_data;
  logic                 m_valid;
  logic                 m_ready;
  logic                 m_last;

  modport master (
    input  fifo_data, fifo_empty, m_ready,
    output fifo_read, m_data, m_valid, m_last
  );

  modport slave (
    output fifo_data, fifo_empty, m_ready,
    input  fifo_read, m_data, m_valid, m_last
  );
endinterface

// File: rtl/fifo_burst_reader.sv
// Burst read master: pops burst_len words from an FWFT fifo and forwards them
// on a valid/ready stream through a 2-entry in-order buffer.
module fifo_burst_reader #(
  parameter int unsigned DATA_BITS = 11,
  parameter int unsigned LEN_BITS  = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [LEN_BITS-1:0] burst_len,
  output logic                busy,
  output logic                done,
  fifo_burst_reader_if.master bus
);

  localparam int unsigned CNT_BITS = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_POP   = 2'd1,
    S_DRAIN = 2'd2,
    S_FIN   = 2'd3
  } state_t;

  state_t                         r_state;
  state_t                         w_state_nxt;
  logic [LEN_BITS-1:0]            r_remaining;
  logic [1:0][DATA_BITS-1:0]      r_buf_data;
  logic [1:0]                     r_buf_last;
  logic                           r_rd_ptr;
  logic                           r_wr_ptr;
  logic [CNT_BITS-1:0]            r_count;
  logic                           r_busy;
  logic                           r_done;
  logic                           w_valid;
  logic                           w_hs;
  logic                           w_push;
  logic                           w_load;
  logic                           w_room;

  assign w_valid = (r_count != CNT_BITS'(0));
  assign w_hs    = w_valid & bus.m_ready;
  // A full buffer can still accept a word when its head leaves this cycle.
  assign w_room  = (r_count < CNT_BITS'(2)) | ((r_count == CNT_BITS'(2)) & w_hs);

  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = (burst_len != LEN_BITS'(0)) ? S_POP : S_FIN;
        end
      end
      S_POP: begin
        w_push = !bus.fifo_empty && (r_remaining != LEN_BITS'(0)) && w_room;
        if (w_push && (r_remaining == LEN_BITS'(1))) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_hs && r_buf_last[r_rd_ptr]) begin
          w_state_nxt = S_FIN;
        end
      end
      S_FIN: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register plus status flags decoded from the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == S_POP) || (w_state_nxt == S_DRAIN);
      r_done  <= (w_state_nxt == S_FIN);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_remaining <= LEN_BITS'(0);
    end else if (w_load) begin
      r_remaining <= burst_len;
    end else if (w_push) begin
      r_remaining <= r_remaining - LEN_BITS'(1);
    end
  end

  // Output buffer storage; the word popped with remaining==1 is the burst tail.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_buf_data <= '0;
      r_buf_last <= 2'b00;
      r_wr_ptr   <= 1'b0;
    end else if (w_push) begin
      r_buf_data[r_wr_ptr] <= bus.fifo_data;
      r_buf_last[r_wr_ptr] <= (r_remaining == LEN_BITS'(1));
      r_wr_ptr             <= ~r_wr_ptr;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_ptr <= 1'b0;
      r_count  <= CNT_BITS'(0);
    end else begin
      if (w_hs) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_hs})
        2'b10:   r_count <= r_count + CNT_BITS'(1);
        2'b01:   r_count <= r_count - CNT_BITS'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign bus.fifo_read = w_push;
  assign bus.m_valid   = w_valid;
  assign bus.m_data    = r_buf_data[r_rd_ptr];
  assign bus.m_last    = w_valid & r_buf_last[r_rd_ptr];
  assign busy          = r_busy;
  assign done          = r_done;

endmodule
